register_file_sb: RTL and testbench

- Parametrised multi-entry successor to the single 16-bit write-enabled register.
- Holds DEPTH registers of WIDTH bits, with one synchronous write port and two combinational read ports.
- Read ports use write-first bypass.
- A per-register busy scoreboard lets the decode stage detect data hazards in the pipelined RISC core; the block sits between decode (read/mark) and writeback (write).

---
 rtl/register_file_sb.sv | 73 +++++++
 tb/tb_register_file_sb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// Parametrised register file with one write port, two write-first read ports
// and a per-register busy scoreboard for decode-stage hazard detection.
module register_file_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             W,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] Din,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] Dout_a,
  output logic [WIDTH-1:0] Dout_b,
  output logic             busy_a,
  output logic             busy_b,
  input  logic             mark,
  input  logic [AW-1:0]    mark_addr,
  output logic             any_busy
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             wr_ok;
  logic             mark_ok;

  // Register 0 is hardwired when ZR: its writes and marks never land.
  assign wr_ok   = W & ~(ZR && (waddr == '0));
  assign mark_ok = mark & ~(ZR && (mark_addr == '0));

  // Clear first, then set, so a new producer issued while the old one
  // retires on the same register leaves it busy.
  always_comb begin
    busy_nxt = busy;
    if (W) busy_nxt[waddr] = 1'b0;
    if (mark_ok) busy_nxt[mark_addr] = 1'b1;
    if (ZR) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) mem[waddr] <= Din;
      busy <= busy_nxt;
    end
  end

  always_comb begin
    Dout_a = mem[raddr_a];
    if (wr_ok && (waddr == raddr_a)) Dout_a = Din;
    if (ZR && (raddr_a == '0)) Dout_a = '0;
  end

  always_comb begin
    Dout_b = mem[raddr_b];
    if (wr_ok && (waddr == raddr_b)) Dout_b = Din;
    if (ZR && (raddr_b == '0)) Dout_b = '0;
  end

  // A write in flight to the read register resolves the hazard this cycle.
  assign busy_a   = busy[raddr_a] & ~(W && (waddr == raddr_a));
  assign busy_b   = busy[raddr_b] & ~(W && (waddr == raddr_b));
  assign any_busy = |busy;

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: directed scenarios plus a
// randomized run checked against an array-based reference model.
module tb_register_file_sb;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk;
  logic             rst;
  logic             W;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] Din;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] Dout_a;
  logic [WIDTH-1:0] Dout_b;
  logic             busy_a;
  logic             busy_b;
  logic             mark;
  logic [AW-1:0]    mark_addr;
  logic             any_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: register contents and outstanding producers.
  logic [WIDTH-1:0] ref_mem [DEPTH];
  bit               ref_busy [DEPTH];

  register_file_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .W(W), .waddr(waddr), .Din(Din),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .Dout_a(Dout_a), .Dout_b(Dout_b),
    .busy_a(busy_a), .busy_b(busy_b), .mark(mark), .mark_addr(mark_addr),
    .any_busy(any_busy)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: what a reader sees right now, from stored state and the write in flight.
  function automatic logic [WIDTH-1:0] m_read(input logic [AW-1:0] ra);
    if (ra == 0) return '0;
    if (W && waddr == ra) return Din;
    return ref_mem[ra];
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] ra);
    return ref_busy[ra] && !(W && waddr == ra);
  endfunction

  function automatic logic m_any();
    for (int i = 0; i < DEPTH; i++) if (ref_busy[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ref_mem[i]  = '0;
        ref_busy[i] = 1'b0;
      end
    end else begin
      if (W && waddr != 0) ref_mem[waddr] = Din;
      if (W) ref_busy[waddr] = 1'b0;
      if (mark && mark_addr != 0) ref_busy[mark_addr] = 1'b1;
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst  = 1'b0;
    W    = 1'b0;
    mark = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; W = 1'b1; waddr = 3'd3; Din = 16'h1111; mark = 1'b1; mark_addr = 3'd3;
    tick();
    idle();
    raddr_a = 3'd3; raddr_b = 3'd5;
    #1;
    n_cmp++; if (Dout_a !== 16'h0) begin n_fail++; $display("FAIL reset_dout_a: got %h expected 0000", Dout_a); end
    n_cmp++; if (Dout_b !== 16'h0) begin n_fail++; $display("FAIL reset_dout_b: got %h expected 0000", Dout_b); end
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
    n_cmp++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b expected 0", busy_b); end
    n_cmp++; if (any_busy !== 1'b0) begin n_fail++; $display("FAIL reset_any_busy: got %b expected 0", any_busy); end
  endtask

  task automatic test_write_read();
    W = 1'b1; waddr = 3'd3; Din = 16'hBEEF;
    tick();
    idle();
    raddr_a = 3'd3;
    #1;
    n_cmp++; if (Dout_a !== 16'hBEEF) begin n_fail++; $display("FAIL write_read: got %h expected beef", Dout_a); end
    rst = 1'b1;
    tick();
    idle();
    #1;
    n_cmp++; if (Dout_a !== 16'h0) begin n_fail++; $display("FAIL write_then_reset: got %h expected 0000", Dout_a); end
  endtask

  task automatic test_bypass();
    W = 1'b1; waddr = 3'd6; Din = 16'h5A5A;
    tick();
    W = 1'b1; waddr = 3'd5; Din = 16'h1234; raddr_a = 3'd5; raddr_b = 3'd5;
    #1;
    n_cmp++; if (Dout_a !== 16'h1234) begin n_fail++; $display("FAIL bypass_a: got %h expected 1234", Dout_a); end
    n_cmp++; if (Dout_b !== 16'h1234) begin n_fail++; $display("FAIL bypass_b: got %h expected 1234", Dout_b); end
    tick();
    idle();
    raddr_b = 3'd6;
    #1;
    n_cmp++; if (Dout_b !== 16'h5A5A) begin n_fail++; $display("FAIL read_old_6: got %h expected 5a5a", Dout_b); end
    n_cmp++; if (Dout_a !== 16'h1234) begin n_fail++; $display("FAIL stored_5: got %h expected 1234", Dout_a); end
  endtask

  task automatic test_zero_reg();
    W = 1'b1; waddr = 3'd0; Din = 16'hFFFF; raddr_a = 3'd0;
    #1;
    n_cmp++; if (Dout_a !== 16'h0) begin n_fail++; $display("FAIL zero_bypass: got %h expected 0000", Dout_a); end
    tick();
    idle();
    #1;
    n_cmp++; if (Dout_a !== 16'h0) begin n_fail++; $display("FAIL zero_read: got %h expected 0000", Dout_a); end
    mark = 1'b1; mark_addr = 3'd0;
    tick();
    idle();
    #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected 0", busy_a); end
    n_cmp++; if (any_busy !== 1'b0) begin n_fail++; $display("FAIL zero_any_busy: got %b expected 0", any_busy); end
  endtask

  task automatic test_scoreboard();
    mark = 1'b1; mark_addr = 3'd2; raddr_a = 3'd2;
    #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL mark_same_cycle: got %b expected 0", busy_a); end
    tick();
    idle();
    #1;
    n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL mark_busy: got %b expected 1", busy_a); end
    n_cmp++; if (any_busy !== 1'b1) begin n_fail++; $display("FAIL mark_any_busy: got %b expected 1", any_busy); end
    W = 1'b1; waddr = 3'd2; Din = 16'h00AA;
    #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL write_resolves: got %b expected 0", busy_a); end
    n_cmp++; if (Dout_a !== 16'h00AA) begin n_fail++; $display("FAIL write_bypass: got %h expected 00aa", Dout_a); end
    n_cmp++; if (any_busy !== 1'b1) begin n_fail++; $display("FAIL any_busy_no_bypass: got %b expected 1", any_busy); end
    tick();
    idle();
    #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL busy_cleared: got %b expected 0", busy_a); end
    n_cmp++; if (any_busy !== 1'b0) begin n_fail++; $display("FAIL any_busy_cleared: got %b expected 0", any_busy); end
  endtask

  task automatic test_set_clear();
    mark = 1'b1; mark_addr = 3'd4; W = 1'b1; waddr = 3'd4; Din = 16'h4444;
    tick();
    idle();
    raddr_a = 3'd4;
    #1;
    n_cmp++; if (Dout_a !== 16'h4444) begin n_fail++; $display("FAIL setclr_data: got %h expected 4444", Dout_a); end
    n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL setclr_set_wins: got %b expected 1", busy_a); end
    mark = 1'b1; mark_addr = 3'd1;
    tick();
    mark_addr = 3'd7;
    tick();
    idle();
    mark = 1'b1; mark_addr = 3'd1; W = 1'b1; waddr = 3'd7; Din = 16'h7777;
    tick();
    idle();
    raddr_a = 3'd1; raddr_b = 3'd7;
    #1;
    n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL remark_busy1: got %b expected 1", busy_a); end
    n_cmp++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL clear_busy7: got %b expected 0", busy_b); end
    n_cmp++; if (Dout_b !== 16'h7777) begin n_fail++; $display("FAIL data7: got %h expected 7777", Dout_b); end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] pat;
    for (int k = 1; k <= 3; k++) begin
      pat = WIDTH'(k * 16'h1111);
      W = 1'b1; waddr = AW'(k); Din = pat; mark = 1'b1; mark_addr = AW'(k);
      tick();
    end
    idle();
    raddr_a = 3'd2;
    #1;
    n_cmp++; if (Dout_a !== 16'h2222) begin n_fail++; $display("FAIL mid_loaded: got %h expected 2222", Dout_a); end
    n_cmp++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy_a); end
    rst = 1'b1; W = 1'b1; waddr = 3'd5; Din = 16'hDEAD; mark = 1'b1; mark_addr = 3'd6;
    tick();
    idle();
    for (int r = 0; r < DEPTH; r++) begin
      raddr_a = AW'(r); raddr_b = AW'(r);
      #1;
      n_cmp++; if (Dout_a !== 16'h0) begin n_fail++; $display("FAIL mid_rst_dout_a[%0d]: got %h expected 0000", r, Dout_a); end
      n_cmp++; if (Dout_b !== 16'h0) begin n_fail++; $display("FAIL mid_rst_dout_b[%0d]: got %h expected 0000", r, Dout_b); end
      n_cmp++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy[%0d]: got %b expected 0", r, busy_a); end
    end
    n_cmp++; if (any_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_any_busy: got %b expected 0", any_busy); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] exp_q[$];
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 39) == 0);
      W         = $urandom_range(0, 1);
      waddr     = AW'($urandom_range(0, DEPTH - 1));
      Din       = WIDTH'($urandom);
      mark      = $urandom_range(0, 1);
      mark_addr = AW'($urandom_range(0, DEPTH - 1));
      raddr_a   = AW'($urandom_range(0, DEPTH - 1));
      raddr_b   = ($urandom_range(0, 3) == 0) ? raddr_a : AW'($urandom_range(0, DEPTH - 1));
      #1;
      exp_q.push_back(m_read(raddr_a));
      exp_q.push_back(m_read(raddr_b));
      n_cmp++; if (Dout_a !== exp_q[0]) begin n_fail++; $display("FAIL rand_dout_a c%0d: got %h expected %h", c, Dout_a, exp_q[0]); end
      n_cmp++; if (Dout_b !== exp_q[1]) begin n_fail++; $display("FAIL rand_dout_b c%0d: got %h expected %h", c, Dout_b, exp_q[1]); end
      exp_q.delete();
      n_cmp++; if (busy_a !== m_busy(raddr_a)) begin n_fail++; $display("FAIL rand_busy_a c%0d: got %b expected %b", c, busy_a, m_busy(raddr_a)); end
      n_cmp++; if (busy_b !== m_busy(raddr_b)) begin n_fail++; $display("FAIL rand_busy_b c%0d: got %b expected %b", c, busy_b, m_busy(raddr_b)); end
      n_cmp++; if (any_busy !== m_any()) begin n_fail++; $display("FAIL rand_any_busy c%0d: got %b expected %b", c, any_busy, m_any()); end
      tick();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]  = '0;
      ref_busy[i] = 1'b0;
    end
    rst = 1'b0; W = 1'b0; waddr = '0; Din = '0; mark = 1'b0; mark_addr = '0;
    raddr_a = '0; raddr_b = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_set_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
